// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage of the miniRISC core.
//
// Holds the program counter, issues word-aligned requests to instruction
// memory over a req/ready handshake and hands each fetched instruction, with
// its PC, to decode over a valid/ready handshake. A small FSM keeps exactly
// one memory request outstanding and throws away responses that a redirect
// has made stale.
//
// Parameters
//   WIDTH     PC, address and instruction width
//   RESET_PC  PC loaded on reset
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   asynchronous reset, active-low
//   redirect     in   one-cycle pulse: replace PC with redirect_pc
//   redirect_pc  in   new PC (low two bits ignored), sampled when redirect=1
//   imem_req     out  request to instruction memory
//   imem_addr    out  request address (the current PC)
//   imem_ready   in   one-cycle pulse: imem_rdata is valid
//   imem_rdata   in   instruction word from memory
//   instr_valid  out  instr / instr_pc hold a valid instruction
//   instr_ready  in   decode accepts the instruction this cycle
//   instr        out  fetched instruction
//   instr_pc     out  PC of instr
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);

  // IDLE : one cycle after reset, no request yet
  // REQ  : request issued (or outstanding) at pc
  // HOLD : instruction presented to decode
  // DROP : a redirect hit an outstanding request; wait for its stale response
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(3);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] instr_next;
  logic [WIDTH-1:0] instr_pc_next;
  logic [WIDTH-1:0] target;

  // Redirect targets are forced word-aligned.
  assign target = redirect_pc & ~ALIGN_MASK;

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      // NOTE: the instruction/PC holding registers are datapath, but they are
      // reset anyway so decode never sees X on instr/instr_pc after reset.
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      instr    <= instr_next;
      instr_pc <= instr_pc_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // does not assign it then holds the register value instead of a latch.
    state_next    = state;
    pc_next       = pc;
    instr_next    = instr;
    instr_pc_next = instr_pc;

    case (state)
      IDLE: begin
        // Any memory response here predates reset release and is ignored.
        state_next = REQ;
        if (redirect) pc_next = target;
      end

      REQ: begin
        if (imem_ready && redirect) begin
          // Response arrives with a redirect: drop it and re-request at once.
          pc_next = target;
        end else if (imem_ready) begin
          instr_next    = imem_rdata;
          instr_pc_next = pc;
          pc_next       = pc + PC_STEP;  // wraps modulo 2^WIDTH
          state_next    = HOLD;
        end else if (redirect) begin
          // The in-flight request cannot be cancelled; its response is stale.
          pc_next    = target;
          state_next = DROP;
        end
      end

      HOLD: begin
        // With instr_ready and redirect together the transfer still
        // completes; the redirect only changes where fetch resumes.
        if (redirect) pc_next = target;
        if (instr_ready || redirect) state_next = REQ;
      end

      DROP: begin
        if (redirect) pc_next = target;
        if (imem_ready) state_next = REQ;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// The bench plays instruction memory (contents are a fixed function of the
// address, latency 1..3 cycles) and decode. A transaction-level model tracks
// the address the next request must use, whether the outstanding request has
// gone stale, and which instruction decode should currently see.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ready;
  logic [W-1:0] imem_rdata;
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;

  fetch_unit #(.WIDTH(W), .RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] exp_pc;      // address the next new request must use
  bit          idle;        // first cycle after reset release
  bit          outst;       // memory has a request in flight
  bit          stale;       // in-flight request was overtaken by a redirect
  int          cnt;         // cycles until memory responds
  logic [31:0] out_addr;
  bit          held;        // decode should see an instruction
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  int          delivered = 0;
  int          lat_fix   = 1;  // 0 = random latency 1..3
  bit          spur      = 1'b0;
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle. Called just after a falling edge: checks the outputs of
  // the current cycle, drives this cycle's inputs, advances the model to what
  // the coming rising edge should produce, then waits for the next falling edge.
  task automatic cycle(input bit r, input logic [31:0] rpc, input bit ir);
    bit rd;
    check("instr_valid", {31'b0, instr_valid}, {31'b0, held});
    if (held) begin
      check("instr", instr, held_instr);
      check("instr_pc", instr_pc, held_pc);
    end
    check("imem_req", {31'b0, imem_req},
          {31'b0, !idle && !held && !(outst && stale)});
    if (imem_req && outst) check("imem_addr_stable", imem_addr, out_addr);

    rd         = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    if (spur) begin
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      spur       = 1'b0;
    end else if (outst) begin
      cnt--;
      if (cnt == 0) begin
        rd         = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = mem_word(out_addr);
      end
    end else if (imem_req) begin
      check("imem_addr", imem_addr, exp_pc);
      req_log.push_back(imem_addr);
      outst    = 1'b1;
      stale    = 1'b0;
      out_addr = exp_pc;
      cnt      = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end
    redirect    = r;
    redirect_pc = rpc;
    instr_ready = ir;

    if (held) begin
      if (ir) begin
        held = 1'b0;
        delivered++;
      end else if (r) begin
        held = 1'b0;
      end
    end
    if (rd) begin
      outst = 1'b0;
      if (!stale && !r) begin
        held       = 1'b1;
        held_pc    = out_addr;
        held_instr = mem_word(out_addr);
        exp_pc     = out_addr + 32'd4;
      end
    end
    if (r) begin
      exp_pc = rpc & ~32'h3;
      if (outst) stale = 1'b1;
    end
    idle = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    outst = 1'b0; stale = 1'b0; held = 1'b0; idle = 1'b1; exp_pc = RPC;
    repeat (2) @(negedge clk);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, RPC);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_until_held(input int budget);
    int n = 0;
    while (!held && n < budget) begin
      cycle(1'b0, 32'd0, 1'b0);
      n++;
    end
    check("reach_hold", {31'b0, held}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    int          d0;

    // Reset and steady-state fetch: latency 1, decode always ready.
    do_reset();
    lat_fix = 1;
    req_log.delete();
    d0 = delivered;
    repeat (10) cycle(1'b0, 32'd0, 1'b1);
    check("seq_addr0", req_log[0], 32'h100);
    check("seq_addr1", req_log[1], 32'h104);
    check("seq_addr2", req_log[2], 32'h108);
    check("throughput", delivered - d0, 32'd3);

    // Decode stall for 5 cycles, then accept.
    run_until_held(20);
    saved = held_pc;
    repeat (5) begin
      cycle(1'b0, 32'd0, 1'b0);
      check("stall_pc", instr_pc, saved);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    cycle(1'b0, 32'd0, 1'b1);
    check("after_stall_req", {31'b0, imem_req}, 32'd1);
    check("after_stall_addr", imem_addr, saved + 32'd4);

    // Redirect to 0x40 while a latency-3 request to 0x10 is in flight.
    run_until_held(20);
    lat_fix = 3;
    cycle(1'b1, 32'h10, 1'b0);
    check("redir_addr", imem_addr, 32'h10);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0);
    check("drop_req", {31'b0, imem_req}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    check("drop_valid", {31'b0, instr_valid}, 32'd0);
    check("drop_next_req", {31'b0, imem_req}, 32'd1);
    check("drop_next_addr", imem_addr, 32'h40);

    // Redirect and imem_ready in the same REQ cycle.
    lat_fix = 1;
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b1, 32'h80, 1'b1);
    check("same_cyc_valid", {31'b0, instr_valid}, 32'd0);
    check("same_cyc_req", {31'b0, imem_req}, 32'd1);
    check("same_cyc_addr", imem_addr, 32'h80);

    // PC wrap and redirect alignment.
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1);
    check("wrap_next_addr", imem_addr, 32'h0);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b1, 32'h23, 1'b1);
    check("align_addr", imem_addr, 32'h20);

    // Randomized traffic.
    lat_fix = 0;
    d0 = delivered;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                        : $urandom;
      cycle($urandom_range(0, 9) == 0, rpc, $urandom_range(0, 2) != 0);
    end
    check("random_progress", {31'b0, delivered > d0 + 50}, 32'd1);

    // Asynchronous reset while holding an instruction.
    lat_fix = 1;
    run_until_held(20);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'b0, instr_valid}, 32'd0);
    check("async_req", {31'b0, imem_req}, 32'd0);
    check("async_addr", imem_addr, RPC);
    do_reset();
    req_log.delete();
    spur = 1'b1;  // stray response in IDLE must be ignored
    cycle(1'b0, 32'd0, 1'b1);
    check("spur_valid", {31'b0, instr_valid}, 32'd0);
    repeat (6) cycle(1'b0, 32'd0, 1'b1);
    check("restart_addr", req_log[0], RPC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
